// File: rtl/cla_pkg.sv
// ----------------------------------------------------------------------------
// cla_pkg
//   Shared definitions for the pipelined carry-look-ahead adder:
//   - legal slice widths (BLOCK_NARROW / BLOCK_WIDE)
//   - cla_stages(): pipeline depth for a given operand and slice width
//   - cla_block_legal(): slice width legality check used at elaboration
//   - cla_generate() / cla_propagate(): per-bit generate and propagate terms,
//     computed at the widest legal slice width; callers cast down to BLOCK
// ----------------------------------------------------------------------------
package cla_pkg;

    localparam int BLOCK_NARROW = 4;
    localparam int BLOCK_WIDE   = 8;
    localparam int BLOCK_MAX    = BLOCK_WIDE;

    function automatic int cla_stages(input int width, input int block);
        return width / block;
    endfunction

    function automatic bit cla_block_legal(input int block);
        return (block == BLOCK_NARROW) || (block == BLOCK_WIDE);
    endfunction

    function automatic logic [BLOCK_MAX-1:0] cla_generate(input logic [BLOCK_MAX-1:0] x,
                                                          input logic [BLOCK_MAX-1:0] y);
        return x & y;
    endfunction

    function automatic logic [BLOCK_MAX-1:0] cla_propagate(input logic [BLOCK_MAX-1:0] x,
                                                           input logic [BLOCK_MAX-1:0] y);
        return x ^ y;
    endfunction

endpackage

// File: rtl/cla_slice.sv
// ----------------------------------------------------------------------------
// cla_slice
//   Purely combinational BLOCK-bit carry-look-ahead adder slice.
//   Ports:
//     a, b  [BLOCK]  slice operands
//     cin   1        slice carry-in
//     s     [BLOCK]  slice sum
//     cout  1        slice carry-out
//     p, g  1        group propagate / group generate of the whole slice
// ----------------------------------------------------------------------------
module cla_slice
    import cla_pkg::*;
#(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] s,
    output logic             cout,
    output logic             p,
    output logic             g
);

    logic [BLOCK-1:0] g_bit;
    logic [BLOCK-1:0] p_bit;
    logic [BLOCK-1:0] g_pre;   // generate of bits i..0 with no carry-in
    logic [BLOCK-1:0] p_pre;   // propagate of bits i..0
    logic [BLOCK-1:0] carry;   // carry into each bit

    assign g_bit = BLOCK'(cla_generate(BLOCK_MAX'(a), BLOCK_MAX'(b)));
    assign p_bit = BLOCK'(cla_propagate(BLOCK_MAX'(a), BLOCK_MAX'(b)));

    // Prefix terms expanded in full so every carry is a flat sum of products
    // of the bit terms and cin, rather than a chain through lower carries.
    always_comb begin
        g_pre = '0;
        p_pre = '0;
        for (int i = 0; i < BLOCK; i++) begin
            g_pre[i] = g_bit[i];
            p_pre[i] = p_bit[i];
            for (int j = i - 1; j >= 0; j--) begin
                g_pre[i] = g_pre[i] | (p_pre[i] & g_bit[j]);
                p_pre[i] = p_pre[i] & p_bit[j];
            end
        end
    end

    always_comb begin
        carry    = '0;
        carry[0] = cin;
        for (int i = 1; i < BLOCK; i++) begin
            carry[i] = g_pre[i-1] | (p_pre[i-1] & cin);
        end
    end

    assign s    = p_bit ^ carry;
    assign g    = g_pre[BLOCK-1];
    assign p    = p_pre[BLOCK-1];
    assign cout = g | (p & cin);

endmodule

// File: rtl/pipelined_cla_adder.sv
// ----------------------------------------------------------------------------
// pipelined_cla_adder
//   s = a + b + c0 over WIDTH bits, one BLOCK-bit CLA slice per pipeline
//   stage; carries ripple between slices through registers only.
//   Latency STAGES = WIDTH/BLOCK cycles, throughput one beat per cycle.
//   The whole pipe advances together whenever the output is not stalled.
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     in_valid / in_ready  operand handshake (in_ready = !out_valid || out_ready)
//     a, b, c0             operands and carry-in
//     out_valid/out_ready  result handshake
//     s, c_out             registered sum and carry-out of the MSB slice
//     ovf                  registered signed overflow (only with CLA_OVF_EN)
//   Build option: define CLA_OVF_EN to add the ovf output.
// ----------------------------------------------------------------------------
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out
`ifdef CLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STAGES = cla_stages(WIDTH, BLOCK);
    // Intermediate (non-output) stages; kept at least 1 so array ranges stay legal.
    localparam int SKEW   = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int LAST   = STAGES - 1;

    if ((WIDTH % BLOCK) != 0) begin : g_width_check
        $error("pipelined_cla_adder: WIDTH must be a multiple of BLOCK");
    end
    if (!cla_block_legal(BLOCK)) begin : g_block_check
        $error("pipelined_cla_adder: BLOCK must be 4 or 8");
    end

    logic adv;

    // Pipeline registers of the intermediate stages. Operands are stored
    // shifted right by one slice per stage, so the next slice to add always
    // sits in the low BLOCK bits; the partial sum keeps finished low slices.
    logic [STAGES-1:0]          vld_p;
    logic [SKEW-1:0][WIDTH-1:0] a_p;
    logic [SKEW-1:0][WIDTH-1:0] b_p;
    logic [SKEW-1:0][WIDTH-1:0] sum_p;
    logic [SKEW-1:0]            carry_p;

    // Per-stage combinational view: inputs of stage k and its slice results.
    logic [STAGES-1:0][WIDTH-1:0] a_in;
    logic [STAGES-1:0][WIDTH-1:0] b_in;
    logic [STAGES-1:0][WIDTH-1:0] sum_in;
    logic [STAGES-1:0][WIDTH-1:0] sum_d;
    logic [STAGES-1:0]            cin;
    logic [STAGES-1:0]            vld_in;
    logic [STAGES-1:0][BLOCK-1:0] slice_s;
    logic [STAGES-1:0]            carry_d;
    logic [STAGES-1:0]            unused_p;
    logic [STAGES-1:0]            unused_g;

    assign out_valid = vld_p[LAST];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({BLOCK{1'b1}}) << (k * BLOCK);

        if (k == 0) begin : g_first
            assign a_in[k]   = a;
            assign b_in[k]   = b;
            assign sum_in[k] = '0;
            assign cin[k]    = c0;
            assign vld_in[k] = in_valid;
        end else begin : g_next
            assign a_in[k]   = a_p[k-1];
            assign b_in[k]   = b_p[k-1];
            assign sum_in[k] = sum_p[k-1];
            assign cin[k]    = carry_p[k-1];
            assign vld_in[k] = vld_p[k-1];
        end

        cla_slice #(
            .BLOCK (BLOCK)
        ) u_slice (
            .a    (a_in[k][BLOCK-1:0]),
            .b    (b_in[k][BLOCK-1:0]),
            .cin  (cin[k]),
            .s    (slice_s[k]),
            .cout (carry_d[k]),
            .p    (unused_p[k]),
            .g    (unused_g[k])
        );

        assign sum_d[k] = (sum_in[k] & ~SLICE_MASK) | (WIDTH'(slice_s[k]) << (k * BLOCK));
    end

    // The MSB slice consumes the last operand bits; anything above them in
    // the final stage's shifted operands is always zero.
    if (WIDTH > BLOCK) begin : g_tail
        logic unused_tail;
        assign unused_tail = ^{a_in[LAST][WIDTH-1:BLOCK], b_in[LAST][WIDTH-1:BLOCK]};
    end

    // Stage boundary: valid bits for every stage
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
        end else if (adv) begin
            vld_p <= vld_in;
        end
    end

    // Stage boundary: intermediate stages (data only, no reset)
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                a_p[k]     <= a_in[k] >> BLOCK;
                b_p[k]     <= b_in[k] >> BLOCK;
                sum_p[k]   <= sum_d[k];
                carry_p[k] <= carry_d[k];
            end
        end
    end

    // Stage boundary: final stage drives the outputs directly
    always_ff @(posedge clk) begin
        if (rst) begin
            s     <= '0;
            c_out <= 1'b0;
`ifdef CLA_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (adv) begin
            s     <= sum_d[LAST];
            c_out <= carry_d[LAST];
`ifdef CLA_OVF_EN
            // Operand sign bits are the top bits of the final slice inputs.
            ovf   <= (a_in[LAST][BLOCK-1] == b_in[LAST][BLOCK-1]) &&
                     (slice_s[LAST][BLOCK-1] != a_in[LAST][BLOCK-1]);
`endif
        end
    end

endmodule
